// File: rtl/fa_sched_pkg.sv
// Shared types and helpers for the bit-serial full-adder scheduler.
// Holds the FSM state type, the counter width helper and the round-robin search.
package fa_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fa_sched_state_t;

    // Widest request vector the round-robin search accepts (N_REQ must not exceed it).
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Returns the first set bit of valid[n-1:0] at or after ptr, searching
    // cyclically, or -1 when nothing is set.
    function automatic int rr_find_first(input logic [RR_MAX_REQ-1:0] valid,
                                         input int n,
                                         input int ptr);
        int idx;
        int j;
        idx = -1;
        // Walk offsets from far to near so the nearest hit is the one that sticks.
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (valid[j[RR_IDX_W-1:0]]) begin
                    idx = j;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fa_bit_slice.sv
// One-bit full adder; written as a plain add so synthesis infers $fa and the
// adder techmap binds it to sky130_osu_sc_12T_hs__addf_1.
module fa_bit_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};

endmodule

// File: rtl/fa_serial_sched.sv
// Round-robin scheduler that time-shares a single full-adder slice among
// N_REQ requesters, evaluating each WIDTH-bit add LSB first, one bit per cycle.
module fa_serial_sched
    import fa_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_ci,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_co,
    output logic                   busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    fa_sched_state_t state;
    fa_sched_state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;

    int               rr_idx;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             rsp_fire;
    logic             last_bit;
    logic             slice_s;
    logic             slice_c;

    fa_bit_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_c)
    );

    // Each new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nxt = slice_s;
        end else begin : g_sum_wn
            assign sum_nxt = {slice_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        rr_idx    = rr_find_first(RR_MAX_REQ'(req_valid), N_REQ, int'(ptr));
        grant_any = (rr_idx >= 0);
        grant_idx = grant_any ? IDW'(rr_idx) : '0;
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign ptr_nxt  = (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready = N_REQ'(1) << grant_idx;
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The pointer only moves on response completion, so fairness is per finished add.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            id     <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= req_a[grant_idx*WIDTH +: WIDTH];
                        b_sh   <= req_b[grant_idx*WIDTH +: WIDTH];
                        carry  <= req_ci[grant_idx];
                        sum_sh <= '0;
                        cnt    <= '0;
                        id     <= grant_idx;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= slice_c;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    if (rsp_fire) begin
                        ptr <= ptr_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_sh;
    assign rsp_co    = carry;
    assign rsp_id    = id;

endmodule

// File: tb/tb_fa_serial_sched.sv
// Self-checking bench for fa_serial_sched: a cycle-level reference model with a
// scoreboard queue for WIDTH=8/N_REQ=2, plus directed checks on a WIDTH=1/N_REQ=1 copy.
module tb_fa_serial_sched;

    localparam int W   = 8;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ci;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_co;
    logic             busy;

    logic             d1_req_valid;
    logic             d1_req_ready;
    logic             d1_a;
    logic             d1_b;
    logic             d1_ci;
    logic             d1_rsp_valid;
    logic             d1_rsp_ready;
    logic             d1_rsp_id;
    logic             d1_rsp_sum;
    logic             d1_rsp_co;
    logic             d1_busy;

    fa_serial_sched #(.WIDTH(W), .N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co),
        .busy      (busy)
    );

    fa_serial_sched #(.WIDTH(1), .N_REQ(1)) dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (d1_req_valid),
        .req_ready (d1_req_ready),
        .req_a     (d1_a),
        .req_b     (d1_b),
        .req_ci    (d1_ci),
        .rsp_valid (d1_rsp_valid),
        .rsp_ready (d1_rsp_ready),
        .rsp_id    (d1_rsp_id),
        .rsp_sum   (d1_rsp_sum),
        .rsp_co    (d1_rsp_co),
        .busy      (d1_busy)
    );

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        logic         co;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   rspIds[$];
    int   passCount  = 0;
    int   checkCount = 0;
    int   cyc        = 0;
    int   modelPtr   = 0;
    int   acceptCount = 0;
    bit   modelIdle  = 1'b1;
    bit   holdValid  = 1'b0;
    bit   randMode   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    function automatic int rrModel(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) begin
                return (p + k) % N;
            end
        end
        return -1;
    endfunction

    task automatic modelReset();
        sb.delete();
        modelPtr  = 0;
        modelIdle = 1'b1;
    endtask

    task automatic randomizeReq(input int i);
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = W'($urandom);
        req_ci[i]       = 1'($urandom_range(0, 1));
        req_valid[i]    = 1'b1;
    endtask

    task automatic applyStimulus(input int i, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_ci[i]       = ci;
        req_valid[i]    = 1'b1;
    endtask

    // One clock cycle: compare every output against the model, advance the
    // model as the handshakes dictate, then move on to the next negedge.
    task automatic tick();
        logic [N-1:0] expReady;
        logic [W:0]   full;
        int           w;
        bit           expRv;
        exp_t         e;
        #1;
        expReady = '0;
        w = -1;
        if (modelIdle) begin
            w = rrModel(req_valid, modelPtr);
            if (w >= 0) expReady[w] = 1'b1;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        expRv = (sb.size() > 0) && (cyc >= sb[0].acc + W + 1);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRv));
        checkOutput("busy", 32'(busy), 32'(!modelIdle));
        if (expRv) begin
            checkOutput("rsp_id",  32'(rsp_id),  32'(sb[0].id));
            checkOutput("rsp_sum", 32'(rsp_sum), 32'(sb[0].sum));
            checkOutput("rsp_co",  32'(rsp_co),  32'(sb[0].co));
            if (rsp_ready) begin
                rspIds.push_back(int'(rsp_id));
                modelPtr = (sb[0].id + 1) % N;
                void'(sb.pop_front());
                modelIdle = 1'b1;
            end
        end
        if (w >= 0) begin
            full = (W+1)'(req_a[w*W +: W]) + (W+1)'(req_b[w*W +: W]) + (W+1)'(req_ci[w]);
            e.id  = w;
            e.sum = full[W-1:0];
            e.co  = full[W];
            e.acc = cyc;
            sb.push_back(e);
            modelIdle = 1'b0;
            acceptCount++;
        end
        @(negedge clk);
        cyc++;
        if (w >= 0) begin
            if (randMode) begin
                if ($urandom_range(0, 3) != 0) randomizeReq(w);
                else req_valid[w] = 1'b0;
            end else if (!holdValid) begin
                req_valid[w] = 1'b0;
            end
        end
        if (randMode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) randomizeReq(i);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (!(modelIdle && sb.size() == 0 && req_valid == '0) && guard < 300) begin
            tick();
            guard++;
        end
        checkOutput("idle_timeout", 32'(guard < 300), 32'd1);
    endtask

    task automatic waitAccept();
        int guard;
        guard = 0;
        while (modelIdle && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("accept_timeout", 32'(guard < 50), 32'd1);
    endtask

    initial begin
        int guard;
        int base;
        rst          = 1'b1;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_ci       = '0;
        rsp_ready    = 1'b1;
        d1_req_valid = 1'b0;
        d1_a         = 1'b0;
        d1_b         = 1'b0;
        d1_ci        = 1'b0;
        d1_rsp_ready = 1'b1;
        modelReset();

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'd0);
        checkOutput("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        checkOutput("rst_rsp_co",    32'(rsp_co),    32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_w1_valid",  32'(d1_rsp_valid), 32'd0);
        checkOutput("rst_w1_busy",   32'(d1_busy),   32'd0);
        rst = 1'b0;

        // Single add and overflow.
        applyStimulus(0, 8'h3C, 8'h51, 1'b0);
        waitIdle();
        applyStimulus(1, 8'hFF, 8'h01, 1'b1);
        waitIdle();

        // Fairness with both requesters holding valid.
        rspIds.delete();
        holdValid = 1'b1;
        applyStimulus(0, 8'h10, 8'h20, 1'b0);
        applyStimulus(1, 8'h10, 8'h20, 1'b0);
        guard = 0;
        while (rspIds.size() < 4 && guard < 200) begin
            tick();
            guard++;
        end
        holdValid = 1'b0;
        req_valid = '0;
        waitIdle();
        checkOutput("grant_count", 32'(rspIds.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < rspIds.size(); k++) begin
            checkOutput("grant_order", 32'(rspIds[k]), 32'(k % 2));
        end

        // Backpressure: five DONE cycles with rsp_ready low.
        rsp_ready = 1'b0;
        applyStimulus(0, 8'hA5, 8'h5A, 1'b1);
        waitAccept();
        repeat (W + 5) tick();
        rsp_ready = 1'b1;
        tick();
        waitIdle();

        // Reset during the fourth RUN cycle, with ptr sitting at 1 beforehand.
        applyStimulus(0, 8'h01, 8'h02, 1'b0);
        waitIdle();
        applyStimulus(1, 8'h77, 8'h11, 1'b0);
        waitAccept();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_busy",  32'(busy),      32'd0);
        checkOutput("mid_rst_sum",   32'(rsp_sum),   32'd0);
        checkOutput("mid_rst_co",    32'(rsp_co),    32'd0);
        checkOutput("mid_rst_id",    32'(rsp_id),    32'd0);
        applyStimulus(0, 8'h12, 8'h34, 1'b1);
        applyStimulus(1, 8'h80, 8'h80, 1'b0);
        waitIdle();

        // WIDTH=1, N_REQ=1 instance.
        d1_req_valid = 1'b1;
        d1_a  = 1'b1;
        d1_b  = 1'b1;
        d1_ci = 1'b1;
        #1;
        checkOutput("w1_req_ready", 32'(d1_req_ready), 32'd1);
        tick();
        d1_req_valid = 1'b0;
        #1;
        checkOutput("w1_run_valid", 32'(d1_rsp_valid), 32'd0);
        checkOutput("w1_run_busy",  32'(d1_busy),      32'd1);
        tick();
        #1;
        checkOutput("w1_rsp_valid", 32'(d1_rsp_valid), 32'd1);
        checkOutput("w1_rsp_sum",   32'(d1_rsp_sum),   32'd1);
        checkOutput("w1_rsp_co",    32'(d1_rsp_co),    32'd1);
        checkOutput("w1_rsp_id",    32'(d1_rsp_id),    32'd0);
        tick();
        #1;
        checkOutput("w1_after_valid", 32'(d1_rsp_valid), 32'd0);
        checkOutput("w1_after_busy",  32'(d1_busy),      32'd0);

        // 1000 random transactions with random valids and backpressure.
        base     = acceptCount;
        randMode = 1'b1;
        randomizeReq(0);
        randomizeReq(1);
        guard = 0;
        while (acceptCount < base + 1000 && guard < 40000) begin
            tick();
            guard++;
        end
        randMode  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        checkOutput("random_count", 32'(acceptCount - base >= 1000), 32'd1);
        waitIdle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fa_serial_sched.md
# fa_serial_sched

Round-robin scheduler that shares one full-adder bit slice among `N_REQ` requesters. Each accepted request is an add of two `WIDTH`-bit operands plus a carry-in. The block evaluates it bit-serially, LSB first, through the single slice (`sky130_osu_sc_12T_hs__addf_1`, one bit per cycle) and returns the sum and carry-out to the winning requester. It sits beside the adder techmap as the area-minimal alternative for low-throughput arithmetic in the sky130 OSU flow.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width; legal range ≥1.
- `N_REQ`, default 2: number of requesters; legal range ≥1.
- `IDW`, default `max(1,$clog2(N_REQ))`: requester-index width (derived).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit is high in any cycle.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B, same packing as `req_a`.
- `req_ci`  in  N_REQ  carry-in, bit i for requester i.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_sum`  out  WIDTH  A+B+CI modulo 2^WIDTH.
- `rsp_co`  out  1  carry-out of the sum, i.e. bit WIDTH.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
State machine: IDLE, RUN, DONE.
- **IDLE**
  - If any `req_valid` is high, the winner is the first set bit at or after the round-robin pointer `ptr`, searching cyclically.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On that edge the block:
    - loads `a_sh` and `b_sh` from the winner's operands;
    - sets `carry` to `req_ci[winner]`;
    - sets `cnt` to 0 and `id` to the winner;
    - moves to RUN.
  - If no `req_valid` is high, the block stays in IDLE and all `req_ready` are 0.
- **RUN**
  - The slice computes `{c,s} = a_sh[0] + b_sh[0] + carry`.
  - On each edge:
    - `a_sh` and `b_sh` shift right by one;
    - `s` shifts into the MSB of `sum_sh`, which also shifts right;
    - `carry` takes `c`;
    - `cnt` increments.
  - When `cnt == WIDTH-1` on an edge, the next state is DONE.
- **DONE**
  - `rsp_valid` = 1, `rsp_sum` = `sum_sh`, `rsp_co` = `carry`, `rsp_id` = `id`.
  - On `rsp_valid && rsp_ready`:
    - `ptr` becomes `(id+1) mod N_REQ`;
    - the state moves to IDLE.
  - While `rsp_ready` is low, the block holds DONE and every output stays stable.
- **Other rules**
  - `req_ready` is 0 in RUN and DONE. A response completing in DONE and a new accept can never occur in the same cycle; the next accept happens at the earliest in the cycle after DONE→IDLE.
  - `ptr` advances only on response completion. An idle requester is never granted.
  - `req_ready[i]` may depend on `req_valid[i]`. Requesters must not make `req_valid` depend on `req_ready`.
  - `N_REQ` = 1: `ptr` is constant 0 and `rsp_id` is constant 0.
  - `WIDTH` = 1: RUN lasts exactly one cycle.
  - Arithmetic is unsigned. Overflow appears only in `rsp_co`.

## Timing
- Reset values: state=IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_co`=0, `busy`=0.
- Reset mid-operation (RUN or DONE): the transaction is aborted with no response and the block returns to the reset values on the next cycle.
- Accept handshake completes at edge T, so state is RUN during cycles T+1..T+WIDTH.
- `rsp_valid` is first high in cycle T+WIDTH+1.
- Minimum request-to-request spacing is WIDTH+2 cycles, with `rsp_ready` held at 1.
- All outputs except `req_ready` are driven directly from registers.
- `req_ready` is one level of priority logic on top of `req_valid` and `ptr`.

## Structure
- Package `fa_sched_pkg` holds:
  - the state enum `fa_sched_state_t` (IDLE, RUN, DONE);
  - the `cnt` width function `max(1,$clog2(WIDTH))`;
  - the round-robin find-first function.
- Sub-module `fa_bit_slice` has ports `a`, `b`, `ci`, `s`, `co`. It is a one-bit `$fa` equivalent that maps to `sky130_osu_sc_12T_hs__addf_1` through the existing adder techmap. It is the only arithmetic in the block.
- The controller (FSM, arbiter, shift registers) is target-independent RTL.

## Test plan
- **Single add.** WIDTH=8, N_REQ=2. Requester 0 sends A=0x3C, B=0x51, CI=0; `rsp_ready`=1.
  - `req_ready[0]` is high for one cycle.
  - The response arrives 9 cycles after the accept edge: sum=0x8D, co=0, id=0.
- **Overflow.** Requester 1 sends A=0xFF, B=0x01, CI=1.
  - Response: sum=0x01, co=1, id=1.
- **Round-robin fairness.**
  - Both requesters hold `req_valid` continuously, each with A=0x10, B=0x20, CI=0.
  - Grant order is 0,1,0,1; every response has sum=0x30.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles in DONE.
  - `rsp_valid`, `rsp_sum`, `rsp_co` and `rsp_id` stay stable.
  - `req_ready` stays at 0 throughout.
  - The response completes on the cycle `rsp_ready` rises.
- **Reset mid-operation.** Assert `rst` for one cycle at cycle 4 of RUN.
  - No response is produced; all outputs and `ptr` are 0 the next cycle.
  - A new request then completes normally.
- **Edge parameters.**
  - WIDTH=1, N_REQ=1: A=1, B=1, CI=1 gives sum=1, co=1, with `rsp_valid` 2 cycles after the accept edge.
  - Random-compare 1000 transactions against A+B+CI.
